// File: rtl/ebox_pkg.sv
// Shared EBOX definitions: DRAM word layout, diagnostic load function codes,
// loader error codes and the DRAM odd-parity helper (also used by IR parity).
package ebox_pkg;

  localparam int unsigned DRAM_WIDTH     = 15;
  localparam int unsigned DRAM_ADDR_BITS = 9;

  // Bit 0 of the DRAM word (A MSB) sits at the vector MSB.
  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       p;
    logic [3:0] j1_4;
    logic [3:0] j7_10;
  } dram_word_t;

  typedef enum logic [2:0] {
    FN_ADDR_HI = 3'd0,
    FN_ADDR_LO = 3'd1,
    FN_AB      = 3'd2,
    FN_PJ1     = 3'd3,
    FN_J7      = 3'd4,
    FN_COMMIT  = 3'd5,
    FN_CLR_ERR = 3'd6,
    FN_NOP     = 3'd7
  } ld_func_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_VERIFY     = 2'd1,
    ERR_INCOMPLETE = 2'd2,
    ERR_PARITY     = 2'd3
  } err_code_e;

  // P value that makes the XOR of all 15 word bits equal 1.
  function automatic logic dram_odd_parity(input dram_word_t w);
    return ~(^{w.a, w.b, w.j1_4, w.j7_10});
  endfunction

endpackage

// File: rtl/dram_field_asm.sv
// DRAM word field registers, load mask and word packing.
// Optional macro DRAM_AUTO_PARITY_EN: P is generated as odd parity and a
// disagreeing loaded P is flagged through p_mismatch.
module dram_field_asm
  import ebox_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_en,
  input  logic [2:0] func,
  input  logic [5:0] data,
  input  logic       clear_mask,
  output logic [2:0] mask,
  output dram_word_t word,
  output logic       p_mismatch
);

  dram_word_t fields;

  // Capture fields on accepted transfers; EBUS data[0] is data[5] here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fields <= '0;
      mask   <= '0;
    end else begin
      if (clear_mask) mask <= '0;
      if (load_en) begin
        case (ld_func_e'(func))
          FN_AB: begin
            fields.a <= data[5:3];
            fields.b <= data[2:0];
            mask[0]  <= 1'b1;
          end
          FN_PJ1: begin
            fields.p    <= data[4];
            fields.j1_4 <= data[3:0];
            mask[1]     <= 1'b1;
          end
          FN_J7: begin
            fields.j7_10 <= data[3:0];
            mask[2]      <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Pack the word presented to the writer.
  always_comb begin
    word       = fields;
    p_mismatch = 1'b0;
`ifdef DRAM_AUTO_PARITY_EN
    word.p     = dram_odd_parity(fields);
    p_mismatch = (fields.p != word.p);
`endif
  end

endmodule

// File: rtl/dram_loader.sv
// Diagnostic-side DRAM writer: assembles a word from 6-bit EBUS transfers,
// writes it, reads it back and verifies. Optional macro DRAM_AUTO_PARITY_EN
// (handled in dram_field_asm) enables generated odd parity.
module dram_loader
  import ebox_pkg::*;
#(
  parameter int unsigned AUTO_INC = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [2:0]                ld_func,
  input  logic [5:0]                ld_data,
  output logic [DRAM_ADDR_BITS-1:0] dram_addr,
  output logic [DRAM_WIDTH-1:0]     dram_din,
  output logic                      dram_we,
  input  logic [DRAM_WIDTH-1:0]     dram_dout,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                err_code
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_CHECK} state_e;

  state_e     state_q, state_d;
  dram_word_t word, din_q;
  logic [2:0] mask;
  logic       p_mismatch;
  err_code_e  err_code_q;
  ld_func_e   func;
  logic       accept, is_commit, commit_go, verify_ok;

  assign func      = ld_func_e'(ld_func);
  assign accept    = ld_valid && (state_q == ST_IDLE);
  assign is_commit = accept && (func == FN_COMMIT);
  assign commit_go = is_commit && (mask == 3'b111);
  assign verify_ok = (dram_dout == din_q);
  assign dram_din  = din_q;
  assign err_code  = err_code_q;

  dram_field_asm u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (accept),
    .func       (ld_func),
    .data       (ld_data),
    .clear_mask (is_commit),
    .mask       (mask),
    .word       (word),
    .p_mismatch (p_mismatch)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-state strobes.
  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    busy     = 1'b1;
    dram_we  = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ld_ready = 1'b1;
        busy     = 1'b0;
        if (commit_go) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        dram_we = 1'b1;
        state_d = ST_READ;
      end
      ST_READ:  state_d = ST_CHECK;
      ST_CHECK: begin
        done    = verify_ok;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Address, write data and sticky error bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dram_addr  <= '0;
      din_q      <= '0;
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      if (accept) begin
        case (func)
          FN_ADDR_HI: dram_addr[DRAM_ADDR_BITS-1 -: 3] <= ld_data[2:0];
          FN_ADDR_LO: dram_addr[5:0] <= ld_data;
          FN_CLR_ERR: begin
            err        <= 1'b0;
            err_code_q <= ERR_NONE;
          end
          FN_COMMIT: begin
            if (mask == 3'b111) begin
              din_q <= word;
              if (p_mismatch) begin
                err        <= 1'b1;
                err_code_q <= ERR_PARITY;
              end
            end else begin
              err        <= 1'b1;
              err_code_q <= ERR_INCOMPLETE;
            end
          end
          default: ;
        endcase
      end
      if (state_q == ST_CHECK) begin
        if (verify_ok) begin
          if (AUTO_INC != 0) dram_addr <= dram_addr + DRAM_ADDR_BITS'(1);
        end else begin
          err        <= 1'b1;
          err_code_q <= ERR_VERIFY;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_loader.sv
// Scoreboard bench for dram_loader; DRAM_AUTO_PARITY_EN adjusts expectations.
module tb_dram_loader;

  logic        clk = 1'b0, rst_n = 1'b0, ld_valid = 1'b0;
  logic [2:0]  ld_func = '0;
  logic [5:0]  ld_data = '0;
  logic        ld_ready, dram_we, busy, done, err;
  logic [8:0]  dram_addr;
  logic [14:0] dram_din, dram_dout;
  logic [1:0]  err_code;

  dram_loader #(.AUTO_INC(1)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_func(ld_func), .ld_data(ld_data), .dram_addr(dram_addr),
    .dram_din(dram_din), .dram_we(dram_we), .dram_dout(dram_dout),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // RAM model with registered read; flip corrupts bit 14 on store.
  logic [14:0] mem [512];
  logic        flip = 1'b0;
  always @(posedge clk) begin
    if (dram_we) mem[dram_addr] <= flip ? (dram_din ^ 15'h4000) : dram_din;
    dram_dout <= mem[dram_addr];
  end

  // kind: 0 write strobe, 1 done pulse, 2 error raised/changed
  typedef struct {
    int          kind;
    logic [8:0]  addr;
    logic [14:0] data;
    int unsigned cyc;
  } ev_t;
  ev_t q[$];

  int n_checks = 0, n_pass = 0;
  logic [8:0] m_addr = '0;
  logic       m_err = 1'b0;
  logic [1:0] m_code = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic sb_check(input int kind, input logic [8:0] a, input logic [14:0] d);
    ev_t e;
    n_checks++;
    if (q.size() == 0) begin
      $display("FAIL sb_unexpected: kind %0d addr %0o data %0o cyc %0d, none required",
               kind, a, d, cyc);
      return;
    end
    e = q.pop_front();
    if (e.kind == kind && e.addr === a && e.data === d && e.cyc == cyc) n_pass++;
    else $display("FAIL sb_event: got kind %0d addr %0o data %0o cyc %0d, required kind %0d addr %0o data %0o cyc %0d",
                  kind, a, d, cyc, e.kind, e.addr, e.data, e.cyc);
  endtask

  // Monitor: compare every DUT-presented event against the queue.
  logic       err_prev = 1'b0;
  logic [1:0] code_prev = '0;
  always @(negedge clk) begin
    if (dram_we === 1'b1) sb_check(0, dram_addr, dram_din);
    if (done === 1'b1) sb_check(1, dram_addr, 15'd0);
    if (err === 1'b1 && (!err_prev || err_code != code_prev))
      sb_check(2, 9'd0, {13'd0, err_code});
    err_prev  = err;
    code_prev = err_code;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [2:0] f, input logic [5:0] d);
    int n = 0;
    ld_func = f; ld_data = d; ld_valid = 1'b1;
    while (!ld_ready && n < 50) begin tick(1); n++; end
    if (!ld_ready) begin
      n_checks++;
      $display("FAIL xfer_timeout: ld_ready %0b, required 1", ld_ready);
      ld_valid = 1'b0;
      return;
    end
    tick(1);
    ld_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!ld_ready && n < 20) begin tick(1); n++; end
    if (!ld_ready) begin
      n_checks++;
      $display("FAIL idle_timeout: ld_ready %0b, required 1", ld_ready);
    end
  endtask

  task automatic clr_err();
    xfer(3'd6, 6'o00);
    m_err = 1'b0; m_code = 2'd0;
  endtask

  task automatic load(input logic [5:0] ab, input logic [5:0] pj, input logic [5:0] j7);
    xfer(3'd2, ab); xfer(3'd3, pj); xfer(3'd4, j7);
  endtask

  // w is the hand-computed word with the loaded P bit.
  task automatic commit_full(input logic [14:0] w, input logic exp_done, input logic exp_verr);
    int unsigned c;
    logic [14:0] wexp;
    wait_idle();
    c = cyc + 1;
    wexp = w;
`ifdef DRAM_AUTO_PARITY_EN
    wexp[8] = ~(^{w[14:9], w[7:0]});
`endif
    q.push_back('{0, m_addr, wexp, c});
    if (wexp[8] != w[8]) begin
      q.push_back('{2, 9'd0, 15'd3, c});
      m_err = 1'b1; m_code = 2'd3;
    end
    if (exp_done) begin
      q.push_back('{1, m_addr, 15'd0, c + 2});
      m_addr = m_addr + 9'd1;
    end
    if (exp_verr) begin
      q.push_back('{2, 9'd0, 15'd1, c + 3});
      m_err = 1'b1; m_code = 2'd1;
    end
    xfer(3'd5, 6'o00);
  endtask

  initial begin
    tick(3);
    chk("rst_ready", ld_ready, 1); chk("rst_busy", busy, 0);
    chk("rst_we", dram_we, 0);     chk("rst_done", done, 0);
    chk("rst_err", err, 0);        chk("rst_code", err_code, 0);
    chk("rst_addr", dram_addr, 0); chk("rst_din", dram_din, 0);
    rst_n = 1'b1;
    tick(1);

    // Full load to 0o354.
    xfer(3'd0, 6'o03); xfer(3'd1, 6'o54); m_addr = 9'o354;
    load(6'o25, 6'o25, 6'o12);
    commit_full(15'o25532, 1'b1, 1'b0);
    chk("full_we", dram_we, 1); chk("full_busy", busy, 1); chk("full_ready", ld_ready, 0);
    tick(3);
    chk("full_addr_inc", dram_addr, 9'o355); chk("full_err", err, m_err);

    // Incomplete commit.
    clr_err();
    xfer(3'd2, 6'o25); xfer(3'd4, 6'o12);
    wait_idle();
    q.push_back('{2, 9'd0, 15'd2, cyc + 1});
    m_err = 1'b1; m_code = 2'd2;
    xfer(3'd5, 6'o00);
    chk("inc_no_we", dram_we, 0); chk("inc_idle", ld_ready, 1);
    chk("inc_err", err, 1);       chk("inc_code", err_code, 2);
    clr_err();
    chk("clr_err", err, 0);       chk("clr_code", err_code, 0);

    // Verify mismatch: readback has bit 14 flipped.
    flip = 1'b1;
    load(6'o70, 6'o12, 6'o05);
    commit_full(15'o70245, 1'b0, 1'b1);
    tick(4);
    flip = 1'b0;
    chk("vmm_err", err, 1); chk("vmm_code", err_code, 1);
    chk("vmm_addr_hold", dram_addr, 9'o355);
    clr_err();

    // Wrap from 0o777.
    xfer(3'd0, 6'o07); xfer(3'd1, 6'o77); m_addr = 9'o777;
    load(6'o00, 6'o77, 6'o77);
    commit_full(15'o00777, 1'b1, 1'b0);
    tick(3);
    chk("wrap_addr", dram_addr, 9'o000); chk("wrap_err", err, m_err);

    // Backpressure: ADDR_LO held during READ/CHECK must not be consumed.
    clr_err();
    load(6'o11, 6'o03, 6'o74);
    commit_full(15'o11074, 1'b1, 1'b0);
    tick(1);
    ld_func = 3'd1; ld_data = 6'o11; ld_valid = 1'b1;
    chk("bp_ready_read", ld_ready, 0); chk("bp_busy_read", busy, 1);
    tick(1);
    chk("bp_ready_check", ld_ready, 0);
    ld_valid = 1'b0;
    tick(1);
    chk("bp_not_consumed", dram_addr, 9'o001);

    // Reset during WRITE.
    clr_err();
    load(6'o77, 6'o40, 6'o00);
    commit_full(15'o77000, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_we", dram_we, 0); chk("mid_rst_idle", ld_ready, 1);
    chk("mid_rst_addr", dram_addr, 9'o000); chk("mid_rst_done", done, 0);
    rst_n = 1'b1; m_addr = '0; m_err = 1'b0; m_code = 2'd0;
    tick(4);

`ifdef DRAM_AUTO_PARITY_EN
    // All-zero fields with loaded P=0: written P must be 1, err_code 3, done still pulses.
    load(6'o00, 6'o00, 6'o00);
    commit_full(15'o00000, 1'b1, 1'b0);
    tick(3);
    chk("par_err", err, 1); chk("par_code", err_code, 3);
    chk("par_addr", dram_addr, 9'o001);
`endif

    tick(3);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL sb_leftover: %0d events outstanding, required 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dram_loader.md
Name: dram_loader

Overview:
- Diagnostic-side writer for the 512x15 dispatch RAM (DRAM). The instruction register only ever reads this RAM.
- Accepts 6-bit diagnostic load transfers from the EBUS diagnostic path (DIAG LOAD function group). Assembles each 15-bit DRAM word field by field, writes it, then reads it back to verify.
- Sits between CTL diagnostic decode and the DRAM write port. Drives addra/dina/wea while the EBOX is halted for microcode/DRAM load.

Parameters:
- DRAM_WIDTH, 15, DRAM word width. Layout: [0:2]=A, [3:5]=B, [6]=P, [7:10]=J[1:4], [11:14]=J[7:10].
- DRAM_ADDR_BITS, 9, DRAM address width (512 words).
- AUTO_INC, 1, when 1 the address increments after each successful commit.

Ports:
- clk  in  1  EBOX clock.
- rst_n  in  1  synchronous active-low reset.
- ld_valid  in  1  diagnostic load transfer present.
- ld_ready  out  1  loader can accept a transfer this cycle.
- ld_func  in  3  field select; equals CTL.DIAG[4:6].
- ld_data  in  6  EBUS data[0:5].
- dram_addr  out  9  DRAM address.
- dram_din  out  15  DRAM write data.
- dram_we  out  1  DRAM write strobe.
- dram_dout  in  15  DRAM read data; registered, valid one cycle after the address.
- busy  out  1  write/verify in progress.
- done  out  1  one-cycle pulse on successful verify.
- err  out  1  sticky error flag; cleared by CLR_ERR.
- err_code  out  2  0 none, 1 verify mismatch, 2 incomplete commit, 3 parity (feature only).

Behaviour:
- Reset is synchronous on rst_n=0. Outputs: state IDLE, dram_addr=0, dram_din=0, dram_we=0, busy=0, done=0, err=0, err_code=0, field mask=0, ld_ready=1.
- A transfer is accepted when ld_valid and ld_ready are both 1. ld_ready = (state==IDLE).
- ld_func decode:
  - 0 ADDR_HI: addr[0:2] = ld_data[3:5].
  - 1 ADDR_LO: addr[3:8] = ld_data.
  - 2 AB: A = ld_data[0:2], B = ld_data[3:5]; sets mask bit 0.
  - 3 PJ1: P = ld_data[1], J[1:4] = ld_data[2:5]; sets mask bit 1.
  - 4 J7: J[7:10] = ld_data[2:5]; sets mask bit 2.
  - 5 COMMIT.
  - 6 CLR_ERR: err=0, err_code=0.
  - 7 no-op.
- Field registers hold their value until overwritten. The mask clears after each commit.
- COMMIT accepted in cycle N:
  - If mask != 3'b111: err=1, err_code=2, no write, stay IDLE.
  - Else N+1 WRITE: dram_we=1, dram_din=assembled word, busy=1.
  - N+2 READ: dram_we=0, same address presented.
  - N+3 CHECK: compare dram_dout to the written word. On match, done=1 for one cycle and the address increments if AUTO_INC (mod 512; 511 wraps to 0). On mismatch, err=1, err_code=1, address unchanged. Return to IDLE at N+4.
- FSM: IDLE -> WRITE -> READ -> CHECK -> IDLE. There are no other paths.
- ld_valid while busy: not accepted (ld_ready=0). Not buffered; the source must hold it.
- An ADDR_HI/ADDR_LO write in the same cycle as an auto-increment cannot occur, because IDLE is required for acceptance.
- A new err overwrites err_code. err stays set until CLR_ERR.
- rst_n=0 during WRITE, READ or CHECK: next cycle IDLE, dram_we=0, no done. A partial write is acceptable because the RAM word is reloaded.

Optional Feature:
- Macro DRAM_AUTO_PARITY_EN.
- When defined:
  - The P bit loaded via PJ1 is ignored.
  - P is generated so that the 15-bit word XOR equals 1 (odd parity).
  - If ld_data[1] differs from the generated P, err=1 and err_code=3. The write still proceeds.
- When undefined: P is taken verbatim from PJ1 and err_code 3 never occurs.

Decomposition:
- Shared package ebox_pkg gets:
  - the dram_word_t struct (A, B, P, J1_4, J7_10);
  - the ld_func enum;
  - the err_code enum;
  - the DRAM_WIDTH/DRAM_ADDR_BITS constants;
  - a dram_odd_parity function, also used by the IR parity check.
- One sub-module: dram_field_asm, the field registers plus mask and word packing. The FSM stays in dram_loader.

Test Plan:
- Full load: ADDR_HI 0o3, ADDR_LO 0o54, AB 0o25, PJ1 0o25, J7 0o12, COMMIT -> dram_we=1 at addr 0o354 with din {A=2,B=5,P=1,J1=0b0101,J7=0b1010}; done pulses 3 cycles after COMMIT; dram_addr becomes 0o355.
- Incomplete: AB and J7 only, then COMMIT -> no dram_we; err=1, err_code=2. CLR_ERR -> err=0.
- Verify mismatch: the bench RAM model flips din bit 14 on readback -> err_code=1, no done, address unchanged.
- Wrap: addr 0o777, full commit -> done, dram_addr=0.
- Busy backpressure plus mid-op reset: ld_valid held during READ -> ld_ready=0 and nothing is consumed. rst_n=0 in WRITE -> next cycle dram_we=0, IDLE, dram_addr=0.
- DRAM_AUTO_PARITY_EN: fields A=0, B=0, J=0, loaded P=0 -> written P=1; err_code=3; done still pulses.
